// File: rtl/linear_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : linear_pkg                                                      |
// | Purpose  : Shared types and helpers for the linear-layer MAC controller.   |
// |            Controller state encoding, default accumulator width and a      |
// |            width-generic saturating add.                                   |
// | Options  : LMC_SATURATE_EN (consumer side) selects the saturating add.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package linear_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } lmc_state_e;

  localparam int unsigned LMC_ACC_W = 32;

  // Unsigned a+b clamped to 2^w-1; operands are zero-extended into 64 bits
  // so one function serves every accumulator width up to 63 bits.
  function automatic logic [63:0] lmc_sat_add(input logic [63:0] a,
                                               input logic [63:0] b,
                                               input int unsigned w);
    logic [64:0] sum;
    logic [64:0] max_v;
    sum   = {1'b0, a} + {1'b0, b};
    max_v = (65'd1 << w) - 65'd1;
    return (sum > max_v) ? max_v[63:0] : sum[63:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/linear_mac_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : linear_mac_pipe                                                 |
// | Purpose  : Two-stage datapath of the MAC controller: feature register      |
// |            (stage 1), multiplier-latency valid bit (stage 2) and the       |
// |            result accumulator.                                             |
// | Ports    : clr_i        clear accumulator (new dot product)                |
// |            hs_i         feature handshake this cycle                       |
// |            feat_data_i  feature chunk, captured on hs_i                    |
// |            w_data_i     weight chunk, arrives one cycle after hs_i         |
// |            mac_acc_i    multiplier partial sum, stage-2 aligned            |
// |            mac_*_o      multiplier operands, zero on bubbles               |
// |            empty_next_o both valid bits will be clear next cycle           |
// |            sat_o        saturation seen (LMC_SATURATE_EN only)             |
// |            acc_o        running dot product                                |
// | Options  : LMC_SATURATE_EN - saturating accumulation + sat_o               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module linear_mac_pipe
  import linear_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             hs_i,
  input  logic [DW-1:0]    feat_data_i,
  input  logic [DW-1:0]    w_data_i,
  input  logic [31:0]      mac_acc_i,
  output logic [DW-1:0]    mac_features_o,
  output logic [DW-1:0]    mac_weights_o,
  output logic             empty_next_o,
`ifdef LMC_SATURATE_EN
  output logic             sat_o,
`endif
  output logic [ACC_W-1:0] acc_o
);

  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic [DW-1:0]    feat_q, feat_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] mac_ext;

  // Partial sum is zero-extended or truncated to the accumulator width.
  assign mac_ext = ACC_W'(mac_acc_i);

`ifdef LMC_SATURATE_EN
  logic sat_q, sat_d;
  logic ovf;
  // a+b overflows exactly when b exceeds the headroom left above a.
  assign ovf = (mac_ext > ~acc_q);
`endif

  always_comb begin
    s1_valid_d = hs_i;
    s2_valid_d = s1_valid_q;
    feat_d     = hs_i ? feat_data_i : feat_q;
    acc_d      = acc_q;
`ifdef LMC_SATURATE_EN
    sat_d      = sat_q;
`endif
    if (clr_i) begin
      acc_d = '0;
`ifdef LMC_SATURATE_EN
      sat_d = 1'b0;
`endif
    end else if (s2_valid_q) begin
`ifdef LMC_SATURATE_EN
      acc_d = ACC_W'(lmc_sat_add(64'(acc_q), 64'(mac_ext), ACC_W));
      sat_d = sat_q | ovf;
`else
      acc_d = acc_q + mac_ext;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      feat_q     <= '0;
      acc_q      <= '0;
`ifdef LMC_SATURATE_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      feat_q     <= feat_d;
      acc_q      <= acc_d;
`ifdef LMC_SATURATE_EN
      sat_q      <= sat_d;
`endif
    end
  end

  // Weight memory output is only meaningful while stage 1 holds a chunk.
  assign mac_features_o = s1_valid_q ? feat_q   : '0;
  assign mac_weights_o  = s1_valid_q ? w_data_i : '0;
  assign empty_next_o   = !s1_valid_d && !s2_valid_d;
  assign acc_o          = acc_q;
`ifdef LMC_SATURATE_EN
  assign sat_o          = sat_q;
`endif

endmodule
`default_nettype wire

// File: rtl/linear_mac_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : linear_mac_ctrl                                                 |
// | Purpose  : Sequences one dot product of an N-chunk feature stream against  |
// |            weights in on-chip memory, driving an NP-lane multiplier and    |
// |            accumulating its partial sums.                                  |
// | Ports    : start/in_len/w_base  command (sampled in IDLE), busy            |
// |            feat_*               feature stream (valid/ready)               |
// |            w_en/w_addr/w_data   weight memory read port (1-cycle latency)  |
// |            mac_*                multiplier interface                       |
// |            res_*                result stream (valid/ready)                |
// | Options  : LMC_SATURATE_EN - saturating accumulate, adds res_sat output    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module linear_mac_ctrl
  import linear_pkg::*;
#(
  parameter int unsigned REG_DEPTH = 8,
  parameter int unsigned NP        = 1,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned ACC_W     = LMC_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        in_len,
  input  logic [ADDR_W-1:0]       w_base,
  output logic                    busy,
  input  logic                    feat_valid,
  output logic                    feat_ready,
  input  logic [NP*REG_DEPTH-1:0] feat_data,
  output logic                    w_en,
  output logic [ADDR_W-1:0]       w_addr,
  input  logic [NP*REG_DEPTH-1:0] w_data,
  output logic                    mac_ce,
  output logic [NP*REG_DEPTH-1:0] mac_features,
  output logic [NP*REG_DEPTH-1:0] mac_weights,
  input  logic [31:0]             mac_acc,
  output logic                    res_valid,
  input  logic                    res_ready,
`ifdef LMC_SATURATE_EN
  output logic                    res_sat,
`endif
  output logic [ACC_W-1:0]        res_data
);

  lmc_state_e        state_q, state_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [LEN_W-1:0]  len_q,   len_d;
  logic [ADDR_W-1:0] base_q,  base_d;
  logic              hs;
  logic              clr;
  logic              pipe_empty_next;

  assign hs     = feat_valid && (state_q == RUN);
  assign w_en   = hs;
  // Address wraps naturally at ADDR_W bits.
  assign w_addr = hs ? (base_q + ADDR_W'(count_q)) : '0;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    len_d      = len_q;
    base_d     = base_q;
    busy       = (state_q != IDLE);
    feat_ready = 1'b0;
    mac_ce     = 1'b0;
    res_valid  = 1'b0;
    clr        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = in_len;
          base_d  = w_base;
          count_d = '0;
          clr     = 1'b1;
          state_d = (in_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        feat_ready = 1'b1;
        mac_ce     = 1'b1;
        if (hs) begin
          count_d = count_q + LEN_W'(1);
          if (count_q == len_q - LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        mac_ce = 1'b1;
        // Leave as the final partial sum is being added, so the result is
        // complete on the first DONE cycle.
        if (pipe_empty_next) state_d = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      len_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      base_q  <= base_d;
    end
  end

`ifdef LMC_SATURATE_EN
  logic sat;
  assign res_sat = res_valid & sat;
`endif

  linear_mac_pipe #(
    .DW    (NP*REG_DEPTH),
    .ACC_W (ACC_W)
  ) u_pipe (
    .clk            (clk),
    .rst            (rst),
    .clr_i          (clr),
    .hs_i           (hs),
    .feat_data_i    (feat_data),
    .w_data_i       (w_data),
    .mac_acc_i      (mac_acc),
    .mac_features_o (mac_features),
    .mac_weights_o  (mac_weights),
    .empty_next_o   (pipe_empty_next),
`ifdef LMC_SATURATE_EN
    .sat_o          (sat),
`endif
    .acc_o          (res_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_linear_mac_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_linear_mac_ctrl                                              |
// | Purpose  : Scoreboard bench for linear_mac_ctrl with a weight memory and   |
// |            a one-cycle multiplier model. A 32-bit accumulator instance     |
// |            runs the main sequences; a 16-bit instance covers overflow.     |
// | Options  : LMC_SATURATE_EN - expects saturation and res_sat on overflow    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_linear_mac_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, busy, feat_valid, feat_ready, w_en, mac_ce;
  logic        res_valid, res_ready;
  logic [15:0] in_len;
  logic [9:0]  w_base, w_addr;
  logic [7:0]  feat_data, mac_features, mac_weights;
  logic [7:0]  w_data  = '0;
  logic [31:0] mac_acc = '0;
  logic [31:0] res_data;

  logic        b_start, b_busy, b_feat_valid, b_feat_ready, b_w_en, b_mac_ce;
  logic        b_res_valid, b_res_ready;
  logic [15:0] b_in_len;
  logic [9:0]  b_w_base, b_w_addr;
  logic [7:0]  b_feat_data, b_mac_features, b_mac_weights;
  logic [7:0]  b_w_data  = '0;
  logic [31:0] b_mac_acc = '0;
  logic [15:0] b_res_data;
`ifdef LMC_SATURATE_EN
  logic        res_sat, b_res_sat;
`endif

  linear_mac_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .in_len(in_len), .w_base(w_base),
    .busy(busy), .feat_valid(feat_valid), .feat_ready(feat_ready),
    .feat_data(feat_data), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .mac_ce(mac_ce), .mac_features(mac_features), .mac_weights(mac_weights),
    .mac_acc(mac_acc), .res_valid(res_valid), .res_ready(res_ready),
`ifdef LMC_SATURATE_EN
    .res_sat(res_sat),
`endif
    .res_data(res_data)
  );

  linear_mac_ctrl #(.ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(b_start), .in_len(b_in_len), .w_base(b_w_base),
    .busy(b_busy), .feat_valid(b_feat_valid), .feat_ready(b_feat_ready),
    .feat_data(b_feat_data), .w_en(b_w_en), .w_addr(b_w_addr), .w_data(b_w_data),
    .mac_ce(b_mac_ce), .mac_features(b_mac_features), .mac_weights(b_mac_weights),
    .mac_acc(b_mac_acc), .res_valid(b_res_valid), .res_ready(b_res_ready),
`ifdef LMC_SATURATE_EN
    .res_sat(b_res_sat),
`endif
    .res_data(b_res_data)
  );

  // Environment: synchronous-read weight memory and registered multiplier.
  logic [7:0] mem [0:1023];
  always @(posedge clk) if (w_en)     w_data   <= mem[w_addr];
  always @(posedge clk) if (b_w_en)   b_w_data <= mem[b_w_addr];
  always @(posedge clk) if (mac_ce)   mac_acc   <= {24'd0, mac_features} * {24'd0, mac_weights};
  always @(posedge clk) if (b_mac_ce) b_mac_acc <= {24'd0, b_mac_features} * {24'd0, b_mac_weights};

  int cyc_cnt = 0;
  int wen_cnt = 0;
  int fr_cnt  = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(negedge clk) begin
    if (w_en)       wen_cnt++;
    if (feat_ready) fr_cnt++;
  end

  int n_pass  = 0;
  int n_total = 0;
  int start_cyc, wen0, fr0, lat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // Scoreboards: stimulus pushes expectations, monitors pop on handshakes.
  logic [31:0] exp_q[$];
  logic [15:0] b_exp_q[$];
  logic        b_sat_q[$];

  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected result: got res_data=%0d, required none", res_data);
      end else begin
        chk("res_data", {32'd0, res_data}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (b_res_valid && b_res_ready) begin
      if (b_exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected result (16b): got res_data=%0d, required none", b_res_data);
      end else begin
        chk("res_data 16b", {48'd0, b_res_data}, {48'd0, b_exp_q.pop_front()});
`ifdef LMC_SATURATE_EN
        chk("res_sat 16b", {63'd0, b_res_sat}, {63'd0, b_sat_q.pop_front()});
`else
        void'(b_sat_q.pop_front());
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] len, input logic [9:0] base);
    start     = 1'b1;
    in_len    = len;
    w_base    = base;
    start_cyc = cyc_cnt;
    wen0      = wen_cnt;
    fr0       = fr_cnt;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input bit do_chk, input logic [9:0] exp_addr);
    feat_valid = 1'b1;
    feat_data  = d;
    @(negedge clk);
    if (do_chk) chk("w_en/w_addr", {53'd0, w_en, w_addr}, {53'd0, 1'b1, exp_addr});
    tick();
    feat_valid = 1'b0;
  endtask

  task automatic wait_valid(output int latency);
    bit found = 1'b0;
    latency = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (res_valid) begin
        found   = 1'b1;
        latency = cyc_cnt - start_cyc;
        break;
      end
    end
    if (!found) begin
      n_total++;
      $display("FAIL timeout: res_valid not seen, required within 60 cycles");
    end
  endtask

  initial begin
    bit stable;
    bit b_found;
    for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
    rst = 1'b1; start = 1'b0; in_len = '0; w_base = '0;
    feat_valid = 1'b0; feat_data = '0; res_ready = 1'b1;
    b_start = 1'b0; b_in_len = '0; b_w_base = '0;
    b_feat_valid = 1'b0; b_feat_data = '0; b_res_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("reset outputs",
        {1'b0, busy, feat_ready, w_en, w_addr, mac_ce, mac_features, mac_weights, res_valid, res_data},
        64'd0);
    tick();
    rst = 1'b0;
    tick();

    // 1*4 + 2*5 + 3*6 = 32, back-to-back
    mem[100] = 8'd4; mem[101] = 8'd5; mem[102] = 8'd6;
    exp_q.push_back(32'd32);
    do_start(16'd3, 10'd100);
    send(8'd1, 1'b1, 10'd100);
    send(8'd2, 1'b1, 10'd101);
    send(8'd3, 1'b1, 10'd102);
    wait_valid(lat);
    chk("latency len3", 64'(lat), 64'd6);
    tick();

    // Empty vector: result 0 on the next cycle, no memory or stream activity
    exp_q.push_back(32'd0);
    do_start(16'd0, 10'd5);
    wait_valid(lat);
    chk("latency len0", 64'(lat), 64'd1);
    tick();
    chk("w_en pulses len0", 64'(wen_cnt - wen0), 64'd0);
    chk("feat_ready pulses len0", 64'(fr_cnt - fr0), 64'd0);

    // Gapped stream: 4 * (2*3) = 24
    for (int i = 0; i < 4; i++) mem[200 + i] = 8'd3;
    exp_q.push_back(32'd24);
    do_start(16'd4, 10'd200);
    for (int i = 0; i < 4; i++) begin
      send(8'd2, 1'b0, 10'd0);
      feat_data = 8'hAA;
      tick();
    end
    wait_valid(lat);
    tick();
    chk("w_en pulses gapped", 64'(wen_cnt - wen0), 64'd4);

    // Back-pressure hold with ignored start pulses: 5*9 = 45
    mem[300] = 8'd9;
    res_ready = 1'b0;
    exp_q.push_back(32'd45);
    do_start(16'd1, 10'd300);
    send(8'd5, 1'b0, 10'd0);
    wait_valid(lat);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      start = 1'b1; in_len = 16'd2; w_base = 10'd0;
      @(negedge clk);
      if (!(res_valid && res_data == 32'd45)) stable = 1'b0;
    end
    chk("held result stable", {63'd0, stable}, 64'd1);
    tick();
    start = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("idle after handshake", {62'd0, busy, res_valid}, 64'd0);
    tick();

    // Abort mid-run after 2 of 5 chunks, then a fresh 7*9 = 63
    for (int i = 0; i < 5; i++) mem[400 + i] = 8'd1;
    do_start(16'd5, 10'd400);
    send(8'd1, 1'b0, 10'd0);
    send(8'd1, 1'b0, 10'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("outputs after abort",
        {1'b0, busy, feat_ready, w_en, w_addr, mac_ce, mac_features, mac_weights, res_valid, res_data},
        64'd0);
    tick();
    mem[500] = 8'd9;
    exp_q.push_back(32'd63);
    do_start(16'd1, 10'd500);
    send(8'd7, 1'b1, 10'd500);
    wait_valid(lat);
    tick();

    // 16-bit accumulator: 2 * 255*255 = 130050 overflows 2^16
    mem[600] = 8'd255; mem[601] = 8'd255;
`ifdef LMC_SATURATE_EN
    b_exp_q.push_back(16'd65535);
    b_sat_q.push_back(1'b1);
`else
    b_exp_q.push_back(16'd64514);
    b_sat_q.push_back(1'b0);
`endif
    b_start = 1'b1; b_in_len = 16'd2; b_w_base = 10'd600;
    tick();
    b_start = 1'b0;
    b_feat_valid = 1'b1; b_feat_data = 8'd255;
    tick(); tick();
    b_feat_valid = 1'b0;
    b_found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (b_res_valid) begin
        b_found = 1'b1;
        break;
      end
    end
    if (!b_found) begin
      n_total++;
      $display("FAIL timeout: 16b res_valid not seen, required within 30 cycles");
    end
    tick(); tick();

    chk("pending results", 64'(exp_q.size()), 64'd0);
    chk("pending results 16b", 64'(b_exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
